hwpe_stream_sink_realign_decoupled: RTL and testbench
=====================================================

HWPE_STREAM_SINK_REALIGN_DECOUPLED -- requirements
Module: hwpe_stream_sink_realign_decoupled

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, stream width in bits (multiple of 8, at least 16).
REQ-002 SHALL have parameter STRB_FIFO_DEPTH, default 4, number of queued line descriptors (power of 2, at least 2).
REQ-003 SHALL have port clk_i  input  1  clock.
REQ-004 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port clear_i  input  1  synchronous clear, same effect as reset.
REQ-006 SHALL have port test_mode_i  input  1  test mode, no functional effect.
REQ-007 SHALL have port ctrl_i  input  ctrl_realign_t  fields enable, first, last, realign, strb_valid, line_length.
REQ-008 SHALL have port strb_i  input  DATA_WIDTH/8  first-beat byte strobe, '1<<r for byte offset r.
REQ-009 SHALL have port flags_o  output  flags_sink_realign_t  fields decoupled_stall, busy, line_done.
REQ-010 SHALL have port push_i  hwpe_stream_intf_stream.sink  DATA_WIDTH  aligned input stream.
REQ-011 SHALL have port pop_o  hwpe_stream_intf_stream.source  DATA_WIDTH  misaligned, strobed output stream toward memory.

Function
REQ-012 SHALL push a descriptor {r = trailing-zero count of strb_i, realign, line_length} into the descriptor FIFO when ctrl_i.enable & first & strb_valid & FIFO not full; SHALL silently drop the descriptor when the FIFO is full.
REQ-013 SHALL drive flags_o.decoupled_stall = FIFO full, combinationally.
REQ-014 SHALL use states IDLE, FIRST, MIDDLE and FLUSH: IDLE->FIRST when the FIFO is non-empty (pop the descriptor); FIRST->MIDDLE on a beat handshake if line_length>1; MIDDLE stays until the beat counter reaches line_length-1; then ->FLUSH if realign & r!=0, else ->IDLE (or ->FIRST if the FIFO is non-empty).
REQ-015 SHALL treat line_length==1 as a one-beat line: FIRST->FLUSH or FIRST->IDLE directly.
REQ-016 SHALL, when r==0 or realign==0, pass data through unchanged with strb '1; N input beats SHALL give N output beats.
REQ-017 SHALL, when realign & r!=0, shift each input beat k left by r bytes; the output beat SHALL be {in_k low bytes, prev high r bytes held in the tail register}.
REQ-018 SHALL, in that case, use strb '1<<r on the first beat and '1 on middle beats.
REQ-019 SHALL, in that case, emit in FLUSH one extra beat carrying the tail in byte lanes 0..r-1 with strb ~('1<<r), for N+1 output beats in total.
REQ-020 SHALL, in FIRST and MIDDLE, connect pop_o.valid = push_i.valid and push_i.ready = pop_o.ready, purely combinational with zero latency.
REQ-021 SHALL, in FLUSH, assert pop_o.valid = 1 and hold push_i.ready = 0; in IDLE both pop_o.valid and push_i.ready SHALL be 0.
REQ-022 SHALL keep pop_o.data and pop_o.strb stable while pop_o.valid & ~pop_o.ready.
REQ-023 SHALL update the tail register only on an input handshake.
REQ-024 SHALL pulse flags_o.line_done for one cycle on the handshake of the last output beat of a line; flags_o.busy SHALL be 1 when the state is not IDLE or the FIFO is non-empty.
REQ-025 SHALL use a beat counter wide enough to hold line_length, reset to 0 at each FIRST entry.
REQ-026 SHALL accept a descriptor push on the same cycle as a pop: occupancy unchanged, data order preserved.

Reset
REQ-027 SHALL, on rst_ni low or clear_i high, set the state to IDLE, empty the FIFO, and zero the counter and tail register.
REQ-028 SHALL, while in reset, drive pop_o.valid=0, push_i.ready=0, pop_o.data=0, pop_o.strb=0 and all flags_o fields 0.
REQ-029 SHALL, on a reset or clear in the middle of a line, abandon the line with no FLUSH beat.

Structure
REQ-030 SHALL take flags_sink_realign_t (and ctrl_realign_t, if not already present) from hwpe_stream_package.
REQ-031 SHALL implement the descriptor FIFO as a sub-module named hwpe_stream_sink_realign_desc_fifo (register-based, full/empty outputs, simultaneous push/pop supported).

Verification
REQ-032 SHALL test DATA_WIDTH=32, r=0, line_length=3, input words A,B,C -> outputs A,B,C with strb 4'hF, no FLUSH beat, line_done on C.
REQ-033 SHALL test r=1, line_length=2, input 0x44332211 then 0x88776655 -> outputs 0x332211xx/4'hE, 0x77665544/4'hF, 0xxxxxxx88/4'h1.
REQ-034 SHALL test r=3, line_length=1, input 0xDDCCBBAA -> outputs 0xAAxxxxxx/4'h8, 0x00DDCCBB/4'h7.
REQ-035 SHALL test pushing 5 descriptors with STRB_FIFO_DEPTH=4 and no output traffic -> decoupled_stall=1 after the 4th push, 5th dropped, exactly 4 lines emitted.
REQ-036 SHALL test random pop_o.ready stalls at 30% over 100 random lines -> byte stream (masked by strb) equal to input, data stable while stalled.
REQ-037 SHALL test rst_ni asserted in MIDDLE of a 4-beat r=2 line -> valid=0 and state IDLE immediately, next line starts clean with strb 4'hC.

Source files
------------

// File: rtl/hwpe_stream_sink_realign_decoupled_pkg.sv
// hwpe_stream_package: shared types for the realigning stream sink.
//   ctrl_realign_t       - per-line control from the address generator
//   flags_sink_realign_t - status returned to the controller
//   realign_desc_t       - queued line descriptor (byte offset, mode, length)
//   realign_state_e      - sink FSM states
package hwpe_stream_package;

  localparam int unsigned LINE_LENGTH_WIDTH = 16;
  // Byte offsets are stored in 8 bits, which covers streams up to 256 bytes wide.
  localparam int unsigned REALIGN_OFFSET_WIDTH = 8;

  typedef struct packed {
    logic                         enable;
    logic                         first;
    logic                         last;
    logic                         realign;
    logic                         strb_valid;
    logic [LINE_LENGTH_WIDTH-1:0] line_length;
  } ctrl_realign_t;

  typedef struct packed {
    logic decoupled_stall;
    logic busy;
    logic line_done;
  } flags_sink_realign_t;

  typedef struct packed {
    logic [REALIGN_OFFSET_WIDTH-1:0] r;
    logic                            realign;
    logic [LINE_LENGTH_WIDTH-1:0]    line_length;
  } realign_desc_t;

  typedef enum logic [1:0] {
    IDLE,
    FIRST,
    MIDDLE,
    FLUSH
  } realign_state_e;

endpackage

// File: rtl/hwpe_stream_sink_realign_decoupled_if.sv
// hwpe_stream_intf_stream: valid/ready stream with byte strobes.
//   valid, ready - handshake (transfer when both are high)
//   data         - DATA_WIDTH payload
//   strb         - one bit per byte lane, 1 = lane carries a valid byte
// Modports: source drives valid/data/strb, sink drives ready.
interface hwpe_stream_intf_stream #(
  parameter int unsigned DATA_WIDTH = 32
);

  logic                    valid;
  logic                    ready;
  logic [DATA_WIDTH-1:0]   data;
  logic [DATA_WIDTH/8-1:0] strb;

  modport source (output valid, output data, output strb, input ready);
  modport sink   (input valid, input data, input strb, output ready);

endinterface

// File: rtl/hwpe_stream_sink_realign_decoupled_desc_fifo.sv
// hwpe_stream_sink_realign_desc_fifo: small register FIFO for line descriptors.
//   clk_i, rst_ni, clear_i - clock, async active-low reset, sync clear
//   push_i, data_i         - write request (ignored while full)
//   pop_i, data_o          - read request (ignored while empty), head entry
//   full_o, empty_o        - occupancy status
// Push and pop in the same cycle are both honoured when not full/empty.
module hwpe_stream_sink_realign_desc_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic             push_ok, pop_ok;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;
  assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; resetting the pointers empties
  // the FIFO, and an entry is never read before it has been written.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/hwpe_stream_sink_realign_decoupled.sv
// hwpe_stream_sink_realign_decoupled: turns an aligned input stream into a
// byte-misaligned, strobed stream toward memory.
//   clk_i, rst_ni, clear_i - clock, async active-low reset, sync clear
//   test_mode_i            - unused functionally
//   ctrl_i, strb_i         - line descriptor request and first-beat strobe
//   flags_o                - decoupled_stall (descriptor FIFO full), busy,
//                            line_done (last output beat accepted)
//   push_i                 - aligned input stream (sink)
//   pop_o                  - realigned output stream (source)
// Descriptors are queued so the address side can run ahead of the data side.
// A realigned line of N input beats yields N+1 output beats: the extra FLUSH
// beat carries the r leftover high bytes of the last input beat.
module hwpe_stream_sink_realign_decoupled
  import hwpe_stream_package::*;
#(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned STRB_FIFO_DEPTH = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    clear_i,
  input  logic                    test_mode_i,
  input  ctrl_realign_t           ctrl_i,
  input  logic [DATA_WIDTH/8-1:0] strb_i,
  output flags_sink_realign_t     flags_o,
  hwpe_stream_intf_stream.sink    push_i,
  hwpe_stream_intf_stream.source  pop_o
);

  localparam int unsigned NB = DATA_WIDTH / 8;

  // Byte offset r is the index of the lowest set strobe bit.
  function automatic logic [REALIGN_OFFSET_WIDTH-1:0] trailing_zeros(input logic [NB-1:0] s);
    trailing_zeros = '0;
    for (int i = NB - 1; i >= 0; i--) begin
      if (s[i]) trailing_zeros = REALIGN_OFFSET_WIDTH'(i);
    end
  endfunction

  realign_state_e                  state_q, state_d;
  realign_desc_t                   cur_q, cur_d;
  realign_desc_t                   new_desc, head_desc;
  logic [LINE_LENGTH_WIDTH-1:0]    cnt_q, cnt_d, last_idx;
  logic [DATA_WIDTH-1:0]           tail_q;
  logic                            fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [REALIGN_OFFSET_WIDTH-1:0] eff_r;
  logic [NB-1:0]                   strb_first, out_strb;
  logic [DATA_WIDTH-1:0]           in_bytes, shifted;
  logic [31:0]                     shamt;
  logic                            out_valid, in_ready, in_hs, line_done, line_end;
  logic                            unused_sigs;

  assign unused_sigs = ^{test_mode_i, ctrl_i.last, push_i.strb};

  // Descriptor queue
  assign new_desc.r           = trailing_zeros(strb_i);
  assign new_desc.realign     = ctrl_i.realign;
  assign new_desc.line_length = ctrl_i.line_length;
  assign fifo_push = ctrl_i.enable & ctrl_i.first & ctrl_i.strb_valid;

  hwpe_stream_sink_realign_desc_fifo #(
    .WIDTH ($bits(realign_desc_t)),
    .DEPTH (STRB_FIFO_DEPTH)
  ) i_desc_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (clear_i),
    .push_i  (fifo_push),
    .data_i  (new_desc),
    .pop_i   (fifo_pop),
    .data_o  (head_desc),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Without realign the line passes straight through, as if r were 0.
  assign eff_r      = cur_q.realign ? cur_q.r : '0;
  assign strb_first = {NB{1'b1}} << eff_r;
  assign last_idx   = (cur_q.line_length == '0) ? '0 : cur_q.line_length - 1'b1;

  // Output beat = {current low bytes, previous high r bytes}. Shifting the
  // {in, tail} pair right by (NB-r) bytes gives exactly that, and reduces to
  // plain pass-through for r == 0. In FLUSH only the tail remains.
  assign in_bytes = (state_q == FLUSH) ? '0 : push_i.data;
  assign shamt    = (NB - 32'(eff_r)) << 3;
  assign shifted  = DATA_WIDTH'({in_bytes, tail_q} >> shamt);

  // NOTE: every signal written here gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    cnt_d     = cnt_q;
    fifo_pop  = 1'b0;
    out_valid = 1'b0;
    in_ready  = 1'b0;
    out_strb  = '0;
    line_done = 1'b0;
    line_end  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          cur_d    = head_desc;
          cnt_d    = '0;
          state_d  = FIRST;
        end
      end
      FIRST, MIDDLE: begin
        out_valid = push_i.valid;
        in_ready  = pop_o.ready;
        out_strb  = (state_q == FIRST) ? strb_first : {NB{1'b1}};
        if (push_i.valid && pop_o.ready) begin
          if (cnt_q >= last_idx) begin
            if (eff_r != '0) begin
              state_d = FLUSH;
            end else begin
              line_done = 1'b1;
              line_end  = 1'b1;
            end
          end else begin
            cnt_d   = cnt_q + 1'b1;
            state_d = MIDDLE;
          end
        end
      end
      FLUSH: begin
        out_valid = 1'b1;
        out_strb  = ~strb_first;
        if (pop_o.ready) begin
          line_done = 1'b1;
          line_end  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Chain straight into the next queued line without an IDLE bubble.
    if (line_end) begin
      if (!fifo_empty) begin
        fifo_pop = 1'b1;
        cur_d    = head_desc;
        cnt_d    = '0;
        state_d  = FIRST;
      end else begin
        state_d = IDLE;
      end
    end

    // A clear silences the stream for its cycle; the registers reset below.
    if (clear_i) begin
      out_valid = 1'b0;
      in_ready  = 1'b0;
      out_strb  = '0;
      line_done = 1'b0;
      fifo_pop  = 1'b0;
    end
  end

  assign in_hs = in_ready & push_i.valid;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cur_q   <= '0;
      cnt_q   <= '0;
      tail_q  <= '0;
    end else if (clear_i) begin
      state_q <= IDLE;
      cur_q   <= '0;
      cnt_q   <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      cnt_q   <= cnt_d;
      if (in_hs) tail_q <= push_i.data;
    end
  end

  assign pop_o.valid  = out_valid;
  assign pop_o.strb   = out_strb;
  assign pop_o.data   = (state_q == IDLE || clear_i) ? '0 : shifted;
  assign push_i.ready = in_ready;

  assign flags_o.decoupled_stall = fifo_full & ~clear_i;
  assign flags_o.busy            = ((state_q != IDLE) | ~fifo_empty) & ~clear_i;
  assign flags_o.line_done       = line_done;

endmodule

// File: tb/tb_hwpe_stream_sink_realign_decoupled.sv
// Self-checking bench for hwpe_stream_sink_realign_decoupled (32-bit, depth 4).
module tb_hwpe_stream_sink_realign_decoupled;
  import hwpe_stream_package::*;

  localparam int DW = 32;
  localparam int MAX_CYC = 2000;

  logic                clk_i = 1'b0;
  logic                rst_ni, clear_i, test_mode_i;
  ctrl_realign_t       ctrl;
  logic [3:0]          strb;
  flags_sink_realign_t flags;

  hwpe_stream_intf_stream #(.DATA_WIDTH(DW)) push_if ();
  hwpe_stream_intf_stream #(.DATA_WIDTH(DW)) pop_if ();

  hwpe_stream_sink_realign_decoupled #(
    .DATA_WIDTH      (DW),
    .STRB_FIFO_DEPTH (4)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .clear_i     (clear_i),
    .test_mode_i (test_mode_i),
    .ctrl_i      (ctrl),
    .strb_i      (strb),
    .flags_o     (flags),
    .push_i      (push_if),
    .pop_o       (pop_if)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
    logic        done;
  } beat_t;

  typedef struct packed {
    int              r;
    bit              realign;
    int              len;
    int              n_out;
    logic [3:0][31:0] din;
    logic [4:0][31:0] dout;
    logic [4:0][3:0]  sout;
  } vec_t;

  int          n_total = 0;
  int          n_pass  = 0;
  logic [31:0] in_q[$];
  beat_t       out_q[$];
  vec_t        vecs[6];

  task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  function automatic logic [31:0] bmask(input logic [3:0] s);
    bmask = '0;
    for (int b = 0; b < 4; b++) bmask[8*b +: 8] = {8{s[b]}};
  endfunction

  // Called at posedge+1; returns at posedge+1 after the descriptor edge.
  task automatic push_desc(input int r, input bit realign, input int len);
    ctrl.enable      = 1'b1;
    ctrl.first       = 1'b1;
    ctrl.last        = (len == 1);
    ctrl.realign     = realign;
    ctrl.strb_valid  = 1'b1;
    ctrl.line_length = 16'(len);
    strb             = 4'(1 << r);
    @(posedge clk_i); #1;
    ctrl = '0;
    strb = '0;
  endtask

  // Feed in_q, collect n_out output beats; outputs sampled on the falling edge.
  task automatic run_stream(input int n_out, input int ready_pct);
    int          cyc = 0;
    int          idx = 0;
    bit          stalled = 0;
    logic [31:0] hd = '0;
    logic [3:0]  hs = '0;
    out_q.delete();
    while ((out_q.size() < n_out || idx < in_q.size()) && cyc < MAX_CYC) begin
      push_if.valid = (idx < in_q.size());
      push_if.data  = push_if.valid ? in_q[idx] : '0;
      pop_if.ready  = ($urandom_range(99) < ready_pct);
      #4;
      if (stalled)
        check(pop_if.valid && pop_if.data == hd && pop_if.strb == hs, "stall_hold", pop_if.data, hd);
      stalled = pop_if.valid && !pop_if.ready;
      hd = pop_if.data;
      hs = pop_if.strb;
      if (pop_if.valid && pop_if.ready)
        out_q.push_back('{data: pop_if.data, strb: pop_if.strb, done: flags.line_done});
      if (push_if.valid && push_if.ready) idx++;
      @(posedge clk_i); #1;
      cyc++;
    end
    push_if.valid = 1'b0;
    push_if.data  = '0;
    pop_if.ready  = 1'b0;
    if (cyc >= MAX_CYC) check(1'b0, "stream_timeout", cyc, MAX_CYC);
  endtask

  initial begin
    vec_t        v;
    logic [7:0]  exp_b[$];
    logic [7:0]  act_b[$];
    logic [3:0]  exp_seq[8];
    int          dones;
    bit          ok;

    // r=0 pass-through, line_done on the last of three beats
    vecs[0] = '{r: 0, realign: 1'b1, len: 3, n_out: 3,
                din:  {32'h0, 32'hC0C1C2C3, 32'hB0B1B2B3, 32'hA0A1A2A3},
                dout: {32'h0, 32'h0, 32'hC0C1C2C3, 32'hB0B1B2B3, 32'hA0A1A2A3},
                sout: {4'h0, 4'h0, 4'hF, 4'hF, 4'hF}};
    // r=1, two beats plus flush
    vecs[1] = '{r: 1, realign: 1'b1, len: 2, n_out: 3,
                din:  {32'h0, 32'h0, 32'h88776655, 32'h44332211},
                dout: {32'h0, 32'h0, 32'h00000088, 32'h77665544, 32'h33221100},
                sout: {4'h0, 4'h0, 4'h1, 4'hF, 4'hE}};
    // r=3, single-beat line
    vecs[2] = '{r: 3, realign: 1'b1, len: 1, n_out: 2,
                din:  {32'h0, 32'h0, 32'h0, 32'hDDCCBBAA},
                dout: {32'h0, 32'h0, 32'h0, 32'h00DDCCBB, 32'hAA000000},
                sout: {4'h0, 4'h0, 4'h0, 4'h7, 4'h8}};
    // realign off with r=2: unchanged data, full strobes, no flush
    vecs[3] = '{r: 2, realign: 1'b0, len: 2, n_out: 2,
                din:  {32'h0, 32'h0, 32'h9ABCDEF0, 32'h12345678},
                dout: {32'h0, 32'h0, 32'h0, 32'h9ABCDEF0, 32'h12345678},
                sout: {4'h0, 4'h0, 4'h0, 4'hF, 4'hF}};
    // r=2, three beats through MIDDLE plus flush
    vecs[4] = '{r: 2, realign: 1'b1, len: 3, n_out: 4,
                din:  {32'h0, 32'hBBAA9988, 32'h77665544, 32'h33221100},
                dout: {32'h0, 32'h0000BBAA, 32'h99887766, 32'h55443322, 32'h11000000},
                sout: {4'h0, 4'h3, 4'hF, 4'hF, 4'hC}};
    // r=1, single-beat line
    vecs[5] = '{r: 1, realign: 1'b1, len: 1, n_out: 2,
                din:  {32'h0, 32'h0, 32'h0, 32'hCAFEBABE},
                dout: {32'h0, 32'h0, 32'h0, 32'h000000CA, 32'hFEBABE00},
                sout: {4'h0, 4'h0, 4'h0, 4'h1, 4'hE}};

    // Reset: outputs must be quiet even with input traffic and a descriptor offered
    rst_ni = 1'b0; clear_i = 1'b0; test_mode_i = 1'b0;
    ctrl = '0; strb = '0;
    push_if.valid = 1'b1; push_if.data = 32'hDEADBEEF; push_if.strb = '0;
    pop_if.ready = 1'b1;
    ctrl.enable = 1'b1; ctrl.first = 1'b1; ctrl.strb_valid = 1'b1; ctrl.line_length = 16'd1;
    repeat (2) @(posedge clk_i);
    #1;
    check(pop_if.valid == 1'b0, "rst_pop_valid", 32'(pop_if.valid), 32'h0);
    check(push_if.ready == 1'b0, "rst_push_ready", 32'(push_if.ready), 32'h0);
    check(pop_if.data == 32'h0, "rst_pop_data", pop_if.data, 32'h0);
    check(pop_if.strb == 4'h0, "rst_pop_strb", 32'(pop_if.strb), 32'h0);
    check(flags == '0, "rst_flags", 32'(flags), 32'h0);
    ctrl = '0; push_if.valid = 1'b0; push_if.data = '0; pop_if.ready = 1'b0;
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    check(flags.busy == 1'b0, "post_rst_busy", 32'(flags.busy), 32'h0);

    // Table-driven single lines
    for (int i = 0; i < 6; i++) begin
      v = vecs[i];
      in_q.delete();
      for (int k = 0; k < v.len; k++) in_q.push_back(v.din[k]);
      push_desc(v.r, v.realign, v.len);
      run_stream(v.n_out, 100);
      check(out_q.size() == v.n_out, $sformatf("v%0d_beats", i), out_q.size(), v.n_out);
      for (int j = 0; j < out_q.size() && j < v.n_out; j++) begin
        check((out_q[j].data & bmask(v.sout[j])) == (v.dout[j] & bmask(v.sout[j])),
              $sformatf("v%0d_b%0d_data", i, j), out_q[j].data, v.dout[j]);
        check(out_q[j].strb == v.sout[j], $sformatf("v%0d_b%0d_strb", i, j), 32'(out_q[j].strb), 32'(v.sout[j]));
        check(out_q[j].done == (j == v.n_out - 1), $sformatf("v%0d_b%0d_done", i, j),
              32'(out_q[j].done), 32'(j == v.n_out - 1));
      end
      check(flags.busy == 1'b0, $sformatf("v%0d_idle", i), 32'(flags.busy), 32'h0);
    end

    // Descriptor FIFO overflow: hold one line open, queue five more
    push_desc(0, 1'b0, 1);
    repeat (2) begin @(posedge clk_i); #1; end
    check(flags.busy == 1'b1, "ovf_busy", 32'(flags.busy), 32'h1);
    push_desc(1, 1'b1, 1);
    check(flags.decoupled_stall == 1'b0, "ovf_stall1", 32'(flags.decoupled_stall), 32'h0);
    push_desc(2, 1'b1, 1);
    check(flags.decoupled_stall == 1'b0, "ovf_stall2", 32'(flags.decoupled_stall), 32'h0);
    push_desc(3, 1'b1, 1);
    check(flags.decoupled_stall == 1'b0, "ovf_stall3", 32'(flags.decoupled_stall), 32'h0);
    push_desc(0, 1'b1, 1);
    check(flags.decoupled_stall == 1'b1, "ovf_stall4", 32'(flags.decoupled_stall), 32'h1);
    push_desc(2, 1'b1, 1);
    check(flags.decoupled_stall == 1'b1, "ovf_stall5", 32'(flags.decoupled_stall), 32'h1);
    in_q.delete();
    for (int k = 0; k < 5; k++) in_q.push_back(32'h01020304 * (k + 1));
    exp_seq = '{4'hF, 4'hE, 4'h1, 4'hC, 4'h3, 4'h8, 4'h7, 4'hF};
    run_stream(8, 100);
    check(out_q.size() == 8, "ovf_beats", out_q.size(), 32'd8);
    dones = 0;
    for (int j = 0; j < out_q.size() && j < 8; j++) begin
      check(out_q[j].strb == exp_seq[j], $sformatf("ovf_b%0d_strb", j), 32'(out_q[j].strb), 32'(exp_seq[j]));
      if (out_q[j].done) dones++;
    end
    check(dones == 5, "ovf_line_dones", dones, 32'd5);
    check(flags.busy == 1'b0, "ovf_fifth_dropped", 32'(flags.busy), 32'h0);

    // Random lines with 30% output stalls: masked byte stream must equal input
    for (int ln = 0; ln < 100; ln++) begin
      int r   = $urandom_range(3);
      bit re  = 1'($urandom_range(1));
      int len = $urandom_range(4, 1);
      int nout = len + ((re && r != 0) ? 1 : 0);
      in_q.delete(); exp_b.delete(); act_b.delete();
      for (int k = 0; k < len; k++) begin
        in_q.push_back($urandom);
        for (int b = 0; b < 4; b++) exp_b.push_back(in_q[k][8*b +: 8]);
      end
      push_desc(r, re, len);
      run_stream(nout, 70);
      dones = 0;
      foreach (out_q[j]) begin
        for (int b = 0; b < 4; b++) if (out_q[j].strb[b]) act_b.push_back(out_q[j].data[8*b +: 8]);
        if (out_q[j].done) dones++;
      end
      ok = (act_b.size() == exp_b.size());
      for (int k = 0; ok && k < exp_b.size(); k++) ok = (act_b[k] == exp_b[k]);
      check(ok, $sformatf("rand%0d_bytes", ln), act_b.size(), exp_b.size());
      check(dones == 1 && out_q.size() == nout && out_q[nout-1].done, $sformatf("rand%0d_done", ln), dones, 32'd1);
    end

    // Synchronous clear in the middle of a line
    in_q = '{32'hA1A2A3A4};
    push_desc(1, 1'b1, 2);
    run_stream(1, 100);
    push_if.valid = 1'b1; push_if.data = 32'h55667788; pop_if.ready = 1'b1;
    clear_i = 1'b1;
    #1;
    check(pop_if.valid == 1'b0, "clr_pop_valid", 32'(pop_if.valid), 32'h0);
    check(push_if.ready == 1'b0, "clr_push_ready", 32'(push_if.ready), 32'h0);
    @(posedge clk_i); #1;
    clear_i = 1'b0;
    check(flags.busy == 1'b0, "clr_idle", 32'(flags.busy), 32'h0);
    push_if.valid = 1'b0; pop_if.ready = 1'b0;

    // Asynchronous reset in MIDDLE of a 4-beat r=2 line
    in_q = '{32'h03020100, 32'h07060504};
    push_desc(2, 1'b1, 4);
    run_stream(2, 100);
    push_if.valid = 1'b1; push_if.data = 32'h0B0A0908; pop_if.ready = 1'b1;
    rst_ni = 1'b0;
    #1;
    check(pop_if.valid == 1'b0, "mid_rst_pop_valid", 32'(pop_if.valid), 32'h0);
    check(push_if.ready == 1'b0, "mid_rst_push_ready", 32'(push_if.ready), 32'h0);
    check(flags.busy == 1'b0, "mid_rst_idle", 32'(flags.busy), 32'h0);
    push_if.valid = 1'b0; pop_if.ready = 1'b0;
    #2 rst_ni = 1'b1;
    @(posedge clk_i); #1;
    in_q = '{32'h11223344};
    push_desc(2, 1'b1, 1);
    run_stream(2, 100);
    check(out_q.size() == 2, "post_rst_beats", out_q.size(), 32'd2);
    if (out_q.size() == 2) begin
      check(out_q[0].strb == 4'hC, "post_rst_first_strb", 32'(out_q[0].strb), 32'hC);
      check((out_q[0].data & 32'hFFFF0000) == 32'h33440000, "post_rst_first_data", out_q[0].data, 32'h33440000);
      check(out_q[1].strb == 4'h3, "post_rst_flush_strb", 32'(out_q[1].strb), 32'h3);
      check((out_q[1].data & 32'h0000FFFF) == 32'h00001122, "post_rst_flush_data", out_q[1].data, 32'h00001122);
    end
    check(flags.busy == 1'b0, "post_rst_idle", 32'(flags.busy), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
